vslc_spi_eeprom_fetch: RTL and testbench

Upstream instruction-fetch stage for the VSLC core. Runs a continuous SPI mode-0 READ (0x03) from a serial EEPROM and delivers one byte per SPI byte-time, each tagged with its 10-bit EEPROM address. Whenever the core requests a restart, it aborts the current read and reissues it from a new start address. All SPI timing is paced by a single-cycle tick strobe from the core's clock divider; the block never uses a derived clock.

---
 rtl/vslc_spi_eeprom_fetch.sv | 179 +++++++++++++++++
 tb/tb_vslc_spi_eeprom_fetch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vslc_spi_eeprom_fetch.sv
// VSLC instruction-fetch front end: continuous SPI mode-0 EEPROM READ stream.
// Optional wake frame (0xAB) before the first READ: define VSLC_EEPROM_WAKE_EN.
module vslc_spi_eeprom_fetch #(
    parameter int          ADDR_W          = 10,
    parameter int          FRAME_ADDR_BITS = 16,
    parameter int          CS_IDLE_TICKS   = 2,
    parameter logic [7:0]  READ_CMD        = 8'h03
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              restart,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              hold_n,
    input  logic              cipo,
    output logic              cs_n,
    output logic              sck,
    output logic              copi,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic [ADDR_W-1:0] byte_addr
);

    localparam int SH_W = 8 + FRAME_ADDR_BITS;
    localparam int BC_W = $clog2(SH_W + 1);
    localparam int IC_W = $clog2(CS_IDLE_TICKS + 1);
    localparam logic [7:0] WAKE_CMD = 8'hAB;

    typedef enum logic [2:0] {
        S_DESEL,
        S_SELECT,
        S_SHIFT,
        S_DATA,
        S_HOLD
    } state_t;

    state_t            state;
    logic [IC_W-1:0]   idle_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [SH_W-2:0]   tx_sh;
    logic [BC_W-1:0]   bit_cnt;
    logic [BC_W-1:0]   last_bit;
    logic [7:0]        rx_sh;
    logic              in_wake;
    logic              wake_pend;
    logic              frame_end;
    logic [SH_W-1:0]   read_frame;
    logic [SH_W-1:0]   wake_frame;
    logic [SH_W-1:0]   next_frame;

    assign read_frame = {READ_CMD, FRAME_ADDR_BITS'(start_addr)};
    assign wake_frame = {WAKE_CMD, {FRAME_ADDR_BITS{1'b0}}};
    assign next_frame = wake_pend ? wake_frame : read_frame;
    assign last_bit   = in_wake ? BC_W'(7) : BC_W'(SH_W - 1);
    assign frame_end  = sck && (bit_cnt == last_bit);

`ifdef VSLC_EEPROM_WAKE_EN
    logic wake_done;
    logic shift_done;

    assign wake_pend  = ~wake_done;
    assign shift_done = tick && !restart &&
                        (state == S_SHIFT) && frame_end;

    // Wake frame is reissued after any abort until one completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wake_done <= 1'b0;
        end else if (shift_done && in_wake) begin
            wake_done <= 1'b1;
        end
    end
`else
    assign wake_pend = 1'b0;
`endif

    // Frame sequencer: deselect gap, command/address shift, byte stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_DESEL;
            idle_cnt   <= '0;
            addr_cnt   <= '0;
            tx_sh      <= '0;
            bit_cnt    <= '0;
            rx_sh      <= '0;
            in_wake    <= 1'b0;
            cs_n       <= 1'b1;
            sck        <= 1'b0;
            copi       <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_addr  <= '0;
        end else begin
            byte_valid <= 1'b0;
            if (restart) begin
                state    <= S_DESEL;
                idle_cnt <= '0;
                bit_cnt  <= '0;
                rx_sh    <= '0;
                cs_n     <= 1'b1;
                sck      <= 1'b0;
                copi     <= 1'b0;
            end else if (tick) begin
                unique case (state)
                    S_DESEL: begin
                        cs_n <= 1'b1;
                        sck  <= 1'b0;
                        copi <= 1'b0;
                        if (int'(idle_cnt) + 1 >= CS_IDLE_TICKS) begin
                            idle_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= S_SELECT;
                            cs_n     <= 1'b0;
                            in_wake  <= wake_pend;
                            copi     <= next_frame[SH_W-1];
                            tx_sh    <= next_frame[SH_W-2:0];
                            addr_cnt <= start_addr;
                        end else begin
                            idle_cnt <= idle_cnt + IC_W'(1);
                        end
                    end
                    S_SELECT: begin
                        state <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (!sck) begin
                            sck <= 1'b1;
                        end else begin
                            sck <= 1'b0;
                            if (frame_end) begin
                                copi    <= 1'b0;
                                bit_cnt <= '0;
                                if (in_wake) begin
                                    state <= S_DESEL;
                                    cs_n  <= 1'b1;
                                end else begin
                                    state <= S_DATA;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BC_W'(1);
                                copi    <= tx_sh[SH_W-2];
                                tx_sh   <= {tx_sh[SH_W-3:0], 1'b0};
                            end
                        end
                    end
                    S_DATA: begin
                        if (!sck) begin
                            sck   <= 1'b1;
                            rx_sh <= {rx_sh[6:0], cipo};
                        end else begin
                            sck <= 1'b0;
                            if (bit_cnt == BC_W'(7)) begin
                                bit_cnt    <= '0;
                                byte_valid <= 1'b1;
                                byte_data  <= rx_sh;
                                byte_addr  <= addr_cnt;
                                addr_cnt   <= addr_cnt + ADDR_W'(1);
                                if (!hold_n) begin
                                    state <= S_HOLD;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BC_W'(1);
                            end
                        end
                    end
                    S_HOLD: begin
                        if (hold_n) begin
                            state <= S_DATA;
                        end
                    end
                    default: begin
                        state <= S_DESEL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vslc_spi_eeprom_fetch.sv
// Bench for vslc_spi_eeprom_fetch: EEPROM slave model with random memory,
// directed restart/hold scenarios and randomized restart addresses.
module tb_vslc_spi_eeprom_fetch;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          restart = 1'b0;
    logic          hold_n = 1'b1;
    logic          cipo = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          cs_n;
    logic          sck;
    logic          copi;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic [AW-1:0] byte_addr;

    int tests = 0;
    int fails = 0;
    int tick_count = 0;
    int div = 0;
    bit tick_en = 1'b0;

    logic [7:0] mem [1024];

    // EEPROM slave model state
    int          hcnt = 0;
    logic [23:0] hdr = '0;
    bit          in_data = 1'b0;
    logic [9:0]  dptr = '0;
    int          dbit = 7;
    logic        psck = 1'b0;
    logic [7:0]  s_cmd = '0;
    logic [15:0] s_addr = '0;

    vslc_spi_eeprom_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .restart    (restart),
        .start_addr (start_addr),
        .hold_n     (hold_n),
        .cipo       (cipo),
        .cs_n       (cs_n),
        .sck        (sck),
        .copi       (copi),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_addr  (byte_addr)
    );

    always #5 clk = ~clk;

    // Divider strobe: one tick every 4 clk.
    always @(negedge clk) begin
        if (tick_en) begin
            div = div + 1;
            if (div == 4) begin
                div = 0;
                tick = 1'b1;
                tick_count++;
            end else begin
                tick = 1'b0;
            end
        end else begin
            tick = 1'b0;
        end
    end

    // Serial EEPROM: capture 24 header bits, then stream mem from the address.
    always @(negedge clk) begin
        if (cs_n !== 1'b0) begin
            hcnt = 0;
            in_data = 1'b0;
            cipo = 1'b0;
        end else if (sck === 1'b1 && psck === 1'b0) begin
            if (hcnt < 24) begin
                hdr = {hdr[22:0], copi};
                hcnt++;
                if (hcnt == 24) begin
                    s_cmd = hdr[23:16];
                    s_addr = hdr[15:0];
                end
            end
        end else if (sck === 1'b0 && psck === 1'b1) begin
            if (hcnt == 24 && !in_data) begin
                in_data = 1'b1;
                dptr = hdr[9:0];
                dbit = 7;
                cipo = mem[dptr][dbit];
            end else if (in_data) begin
                if (dbit == 0) begin
                    dbit = 7;
                    dptr = dptr + 10'd1;
                end else begin
                    dbit = dbit - 1;
                end
                cipo = mem[dptr][dbit];
            end
        end
        psck = sck;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_byte(input logic [AW-1:0] ea, input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (byte_valid !== 1'b1 && n < 3000);
        chk({tag, "_valid"}, 32'(byte_valid), 32'd1);
        chk({tag, "_addr"}, 32'(byte_addr), 32'(ea));
        chk({tag, "_data"}, 32'(byte_data), 32'(mem[ea]));
    endtask

    task automatic wait_cs_low(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (cs_n !== 1'b0 && n < 1000);
        chk({tag, "_cs_low"}, 32'(cs_n), 32'd0);
    endtask

    task automatic pulse_restart(input logic [AW-1:0] sa);
        start_addr = sa;
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ra;
        int base;
        int t0;
        int n;
        int bad;
        int nb;

        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'($urandom);
        end
        mem[0] = 8'hA5;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_copi", 32'(copi), 32'd0);
        chk("rst_valid", 32'(byte_valid), 32'd0);
        chk("rst_data", 32'(byte_data), 32'd0);
        chk("rst_addr", 32'(byte_addr), 32'd0);

        // first frame from reset
        rst = 1'b0;
        tick_en = 1'b1;
        wait_cs_low("t1");
        chk("t1_cs_fall_ticks", tick_count, 2);
        wait_byte(10'h000, "t1b0");
        chk("t1_latency", tick_count, 67);
        chk("t1_cmd", 32'(s_cmd), 32'h03);
        chk("t1_hdr_addr", 32'(s_addr), 32'h0000);

        // address wrap across the top of the space
        mem[10'h3FE] = 8'h11;
        mem[10'h3FF] = 8'h22;
        mem[10'h000] = 8'h33;
        pulse_restart(10'h3FE);
        chk("t2_cs_high", 32'(cs_n), 32'd1);
        base = tick_count;
        wait_byte(10'h3FE, "t2b0");
        chk("t2_latency", tick_count - base, 67);
        chk("t2_hdr_addr", 32'(s_addr), 32'h03FE);
        t0 = tick_count;
        wait_byte(10'h3FF, "t2b1");
        chk("t2_gap1", tick_count - t0, 16);
        t0 = tick_count;
        wait_byte(10'h000, "t2b2");
        chk("t2_gap2", tick_count - t0, 16);

        // hold at the byte-0 boundary for 50 ticks
        mem[1] = 8'h5A;
        hold_n = 1'b0;
        pulse_restart(10'h000);
        wait_byte(10'h000, "t3b0");
        t0 = tick_count;
        bad = 0;
        n = 0;
        while (tick_count < t0 + 50 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (cs_n !== 1'b0 || sck !== 1'b0 || byte_valid !== 1'b0) bad++;
        end
        chk("t3_hold_pins", bad, 0);
        chk("t3_hold_ticks", tick_count - t0, 50);
        hold_n = 1'b1;
        t0 = tick_count;
        wait_byte(10'h001, "t3b1");
        chk("t3_resume_ticks", tick_count - t0, 17);

        // restart midway through byte 2
        t0 = tick_count;
        n = 0;
        while (tick_count < t0 + 8 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        pulse_restart(10'h010);
        chk("t4_cs_high", 32'(cs_n), 32'd1);
        chk("t4_sck_low", 32'(sck), 32'd0);
        base = tick_count;
        wait_byte(10'h010, "t4b0");
        chk("t4_latency", tick_count - base, 67);
        chk("t4_hdr_addr", 32'(s_addr), 32'h0010);

        // restart coincident with the 8th falling tick of the next byte
        t0 = tick_count;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(tick_count == t0 + 16 && tick === 1'b1) && n < 1000);
        chk("t5_align", tick_count - t0, 16);
        ra = AW'($urandom);
        pulse_restart(ra);
        chk("t5_no_valid", 32'(byte_valid), 32'd0);
        chk("t5_cs_high", 32'(cs_n), 32'd1);
        base = tick_count;
        wait_cs_low("t5");
        chk("t5_idle_ticks", tick_count - base, 2);
        wait_byte(ra, "t5b0");
        chk("t5_latency", tick_count - base, 67);
        chk("t5_hdr_addr", 32'(s_addr), 32'(ra));

        // randomized restarts with short streams
        for (int k = 0; k < 3; k++) begin
            ra = AW'($urandom);
            nb = int'($urandom_range(1, 3));
            pulse_restart(ra);
            base = tick_count;
            for (int b = 0; b < nb; b++) begin
                wait_byte(ra + AW'(b), "rnd");
                chk("rnd_time", tick_count - base, 67 + 16 * b);
            end
            chk("rnd_hdr_addr", 32'(s_addr), 32'(ra));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
